// File: rtl/load_store_unit.sv
// Load/store unit: formats RAM requests from execute and extends load results for writeback.
// Latency: 2 cycles from request accept to resp_valid when mem_ready is already high; errors respond after 1 cycle.
// Backpressure: req_ready is high only in RAM_IDLE. RAM_WAIT holds until mem_ready, or until timeout when LSU_TIMEOUT_EN is defined.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_err,
   output logic        mem_ren,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_strobe,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   typedef enum logic [1:0] {RAM_IDLE, RAM_WAIT, RAM_DONE} ram_state_t;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_MISALGN = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL = 2'b10;

   ram_state_t  state_q, state_d;
   logic        wen_q, wen_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  lane_q, lane_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic [1:0]  resp_err_q, resp_err_d;
   logic        mem_ren_q, mem_ren_d;
   logic        mem_wen_q, mem_wen_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_strobe_q, mem_strobe_d;

   logic        req_illegal;
   logic        req_misaligned;
   logic [15:0] ld_sh;
   logic [31:0] ld_result;

`ifdef LSU_TIMEOUT_EN
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   // Classify the incoming request: illegal codes take priority over alignment
   always_comb begin
      req_illegal    = 1'b0;
      req_misaligned = 1'b0;
      if (req_wen) begin
         req_illegal = (req_funct3 > 3'd2);
      end else begin
         req_illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
      end
      req_misaligned = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
   end

   // Shift the addressed lane down and sign/zero-extend for the latched load code
   always_comb begin
      ld_sh     = 16'(mem_rdata >> {lane_q, 3'b000});
      ld_result = mem_rdata;
      case (f3_q)
         F3_LB:   ld_result = {{24{ld_sh[7]}}, ld_sh[7:0]};
         F3_LH:   ld_result = {{16{ld_sh[15]}}, ld_sh};
         F3_LBU:  ld_result = {24'h0, ld_sh[7:0]};
         F3_LHU:  ld_result = {16'h0, ld_sh};
         default: ld_result = mem_rdata;
      endcase
   end

   // Next-state and registered-output logic for the RAM sequencer
   always_comb begin
      state_d      = state_q;
      wen_d        = wen_q;
      f3_d         = f3_q;
      lane_d       = lane_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      mem_ren_d    = mem_ren_q;
      mem_wen_d    = mem_wen_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_strobe_d = mem_strobe_q;
`ifdef LSU_TIMEOUT_EN
      cnt_d        = cnt_q;
`endif
      case (state_q)
         RAM_IDLE: begin
            if (req_valid) begin
               wen_d  = req_wen;
               f3_d   = req_funct3;
               lane_d = req_addr[1:0];
               if (req_illegal || req_misaligned) begin
                  // Rejected requests never touch the RAM port
                  resp_err_d   = req_illegal ? ERR_ILLEGAL : ERR_MISALGN;
                  resp_rdata_d = 32'h0;
                  resp_valid_d = 1'b1;
                  state_d      = RAM_DONE;
               end else begin
                  mem_ren_d  = ~req_wen;
                  mem_wen_d  = req_wen;
                  mem_addr_d = {req_addr[31:2], 2'b00};
                  if (req_wen) begin
                     case (req_funct3[1:0])
                        2'd0: begin
                           mem_wdata_d  = {4{req_wdata[7:0]}};
                           mem_strobe_d = 4'b0001 << req_addr[1:0];
                        end
                        2'd1: begin
                           mem_wdata_d  = {2{req_wdata[15:0]}};
                           mem_strobe_d = req_addr[1] ? 4'b1100 : 4'b0011;
                        end
                        default: begin
                           mem_wdata_d  = req_wdata;
                           mem_strobe_d = 4'b1111;
                        end
                     endcase
                  end else begin
                     mem_wdata_d  = 32'h0;
                     mem_strobe_d = 4'b1111;
                  end
`ifdef LSU_TIMEOUT_EN
                  cnt_d = '0;
`endif
                  state_d = RAM_WAIT;
               end
            end
         end
         RAM_WAIT: begin
            if (mem_ready) begin
               mem_ren_d    = 1'b0;
               mem_wen_d    = 1'b0;
               resp_rdata_d = wen_q ? 32'h0 : ld_result;
               resp_err_d   = ERR_OK;
               resp_valid_d = 1'b1;
               state_d      = RAM_DONE;
            end
`ifdef LSU_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               // This is the TIMEOUT_CYCLES-th wait cycle without a reply
               mem_ren_d    = 1'b0;
               mem_wen_d    = 1'b0;
               resp_rdata_d = 32'h0;
               resp_err_d   = 2'b11;
               resp_valid_d = 1'b1;
               state_d      = RAM_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         RAM_DONE: begin
            state_d = RAM_IDLE;
         end
         default: begin
            state_d = RAM_IDLE;
         end
      endcase
   end

   // State and output registers; reset clears the RAM request immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RAM_IDLE;
         wen_q        <= 1'b0;
         f3_q         <= 3'd0;
         lane_q       <= 2'd0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 2'b00;
         mem_ren_q    <= 1'b0;
         mem_wen_q    <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= 32'h0;
         mem_strobe_q <= 4'h0;
      end else begin
         state_q      <= state_d;
         wen_q        <= wen_d;
         f3_q         <= f3_d;
         lane_q       <= lane_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         mem_ren_q    <= mem_ren_d;
         mem_wen_q    <= mem_wen_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_strobe_q <= mem_strobe_d;
      end
   end

`ifdef LSU_TIMEOUT_EN
   // Wait-cycle counter for the bus timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign req_ready  = (state_q == RAM_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign mem_ren    = mem_ren_q;
   assign mem_wen    = mem_wen_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_strobe = mem_strobe_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: formatting, errors, wait stability, async reset abort.
// Request/response timing counted in cycles from the accept edge.
// The RAM reply is modelled by driving mem_ready after a chosen number of wait cycles.
module tb_load_store_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_strobe;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   int n_tests;
   int n_fail;

   // Results of the last transaction
   int          r_lat;
   logic [31:0] r_rd;
   logic [1:0]  r_err;
   logic        r_any;
   logic        r_stable;
   logic        s_ren, s_wen;
   logic [31:0] s_addr, s_wdata;
   logic [3:0]  s_strobe;

   load_store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wen    (req_wen),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_ren    (mem_ren),
      .mem_wen    (mem_wen),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_strobe (mem_strobe),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request; the RAM answers after 'delay' wait cycles without mem_ready
   task automatic run_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int delay, input logic [31:0] rdata);
      @(negedge clk);
      chk("ready_before_req", {31'h0, req_ready}, 32'h1);
      req_valid  = 1'b1;
      req_wen    = wen;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      mem_ready  = 1'b0;
      mem_rdata  = rdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      r_lat    = -1;
      r_any    = 1'b0;
      r_stable = 1'b1;
      for (int cyc = 1; cyc <= 60 && r_lat < 0; cyc++) begin
         @(negedge clk);
         if (mem_ren || mem_wen) r_any = 1'b1;
         if (resp_valid) begin
            r_lat = cyc;
            r_rd  = resp_rdata;
            r_err = resp_err;
         end else if (cyc == 1) begin
            s_ren = mem_ren; s_wen = mem_wen; s_addr = mem_addr;
            s_wdata = mem_wdata; s_strobe = mem_strobe;
         end else if (cyc <= delay + 1) begin
            if (mem_ren !== s_ren || mem_wen !== s_wen || mem_addr !== s_addr ||
                mem_wdata !== s_wdata || mem_strobe !== s_strobe) r_stable = 1'b0;
         end
         mem_ready = (cyc >= delay + 1);
      end
      mem_ready = 1'b0;
      if (r_lat < 0) begin
         chk("resp_timeout", 32'h0, 32'h1);
         r_rd  = 32'hx;
         r_err = 2'bx;
      end else begin
         @(negedge clk);
         chk("resp_one_cycle", {31'h0, resp_valid}, 32'h0);
         chk("ready_after_resp", {31'h0, req_ready}, 32'h1);
      end
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_wen    = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      mem_rdata  = 32'h0;
      mem_ready  = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_req_ready",  {31'h0, req_ready},  32'h1);
      chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_resp_err",   {30'h0, resp_err}, 32'h0);
      chk("rst_mem_req",    {30'h0, mem_ren, mem_wen}, 32'h0);
      chk("rst_mem_addr",   mem_addr, 32'h0);
      chk("rst_mem_wdata",  mem_wdata, 32'h0);
      chk("rst_strobe",     {28'h0, mem_strobe}, 32'h0);
      rst = 1'b0;

      // LB sign-extends byte 2 of 0x12F45678
      run_req(1'b0, 3'd0, 32'h0000_0102, 32'h0, 0, 32'h12F4_5678);
      chk("lb_ren_wen", {30'h0, s_ren, s_wen}, 32'h2);
      chk("lb_addr",    s_addr, 32'h0000_0100);
      chk("lb_strobe",  {28'h0, s_strobe}, 32'hF);
      chk("lb_lat",     r_lat, 2);
      chk("lb_rdata",   r_rd, 32'hFFFF_FFF4);
      chk("lb_err",     {30'h0, r_err}, 32'h0);

      run_req(1'b0, 3'd4, 32'h0000_0102, 32'h0, 0, 32'h12F4_5678);
      chk("lbu_rdata",  r_rd, 32'h0000_00F4);
      chk("lbu_lat",    r_lat, 2);

      // SH to the upper half-word
      run_req(1'b1, 3'd1, 32'h0000_0206, 32'hABCD_1234, 0, 32'hFFFF_FFFF);
      chk("sh_ren_wen", {30'h0, s_ren, s_wen}, 32'h1);
      chk("sh_addr",    s_addr, 32'h0000_0204);
      chk("sh_wdata",   s_wdata, 32'h1234_1234);
      chk("sh_strobe",  {28'h0, s_strobe}, 32'hC);
      chk("sh_rdata",   r_rd, 32'h0);
      chk("sh_err",     {30'h0, r_err}, 32'h0);

      // SB to lane 3
      run_req(1'b1, 3'd0, 32'h0000_0503, 32'h0000_00A5, 0, 32'h0);
      chk("sb_wdata",   s_wdata, 32'hA5A5_A5A5);
      chk("sb_strobe",  {28'h0, s_strobe}, 32'h8);

      // Misaligned LW: no RAM access, response next cycle
      run_req(1'b0, 3'd2, 32'h0000_0301, 32'h0, 0, 32'h0);
      chk("lw_mis_access", {31'h0, r_any}, 32'h0);
      chk("lw_mis_lat",    r_lat, 1);
      chk("lw_mis_err",    {30'h0, r_err}, 32'h1);

      // Illegal store code 5
      run_req(1'b1, 3'd5, 32'h0000_0000, 32'h0, 0, 32'h0);
      chk("st5_access", {31'h0, r_any}, 32'h0);
      chk("st5_lat",    r_lat, 1);
      chk("st5_err",    {30'h0, r_err}, 32'h2);

      // Illegal load code 6, misaligned SW
      run_req(1'b0, 3'd6, 32'h0000_0000, 32'h0, 0, 32'h0);
      chk("ld6_err",    {30'h0, r_err}, 32'h2);
      run_req(1'b1, 3'd2, 32'h0000_0702, 32'h0, 0, 32'h0);
      chk("sw_mis_err", {30'h0, r_err}, 32'h1);
      chk("sw_mis_access", {31'h0, r_any}, 32'h0);

      // LH with 5 wait cycles before mem_ready
      run_req(1'b0, 3'd1, 32'h0000_0400, 32'h0, 5, 32'h0000_8001);
      chk("lh_stable",  {31'h0, r_stable}, 32'h1);
      chk("lh_addr",    s_addr, 32'h0000_0400);
      chk("lh_lat",     r_lat, 7);
      chk("lh_rdata",   r_rd, 32'hFFFF_8001);

      // LHU from the upper half, LW full word
      run_req(1'b0, 3'd5, 32'h0000_0602, 32'h0, 1, 32'h8001_1234);
      chk("lhu_rdata",  r_rd, 32'h0000_8001);
      chk("lhu_lat",    r_lat, 3);
      run_req(1'b0, 3'd2, 32'h0000_0800, 32'h0, 0, 32'hDEAD_BEEF);
      chk("lw_rdata",   r_rd, 32'hDEAD_BEEF);

      // Reset during the wait of an SW aborts it asynchronously
      @(negedge clk);
      req_valid  = 1'b1;
      req_wen    = 1'b1;
      req_funct3 = 3'd2;
      req_addr   = 32'h0000_0900;
      req_wdata  = 32'h5566_7788;
      mem_ready  = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("abort_wen_before", {31'h0, mem_wen}, 32'h1);
      #2 rst = 1'b1;
      #1 chk("abort_wen_async", {31'h0, mem_wen}, 32'h0);
      r_any = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid) r_any = 1'b1;
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid) r_any = 1'b1;
      end
      chk("abort_no_resp", {31'h0, r_any}, 32'h0);
      run_req(1'b1, 3'd2, 32'h0000_0900, 32'h1122_3344, 0, 32'h0);
      chk("post_rst_wdata", s_wdata, 32'h1122_3344);
      chk("post_rst_lat",   r_lat, 2);
      chk("post_rst_err",   {30'h0, r_err}, 32'h0);

`ifdef LSU_TIMEOUT_EN
      // mem_ready never arrives: timeout after 4 wait cycles
      run_req(1'b0, 3'd2, 32'h0000_0A00, 32'h0, 1000, 32'hFFFF_FFFF);
      chk("to_lat",   r_lat, 5);
      chk("to_err",   {30'h0, r_err}, 32'h3);
      chk("to_rdata", r_rd, 32'h0);
      chk("to_ren_dropped", {31'h0, mem_ren}, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle data-memory access stage between execute and the data RAM port.
- Accepts one load or store request per transaction, encoded with the core's funct3 load/store codes (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Aligns store data and generates byte strobes, waits on the RAM handshake, then extracts and sign/zero-extends load data for writeback.
- Sequencing uses the shared ram_state_t states RAM_IDLE, RAM_WAIT and RAM_DONE.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles spent in RAM_WAIT before a bus error (only with the optional feature).
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  execute presents a request.
- req_ready  out  1  unit can accept a request (state RAM_IDLE).
- req_wen  in  1  1 = store, 0 = load.
- req_funct3  in  3  funct3_ld_i_t code for loads, funct3_s_t code for stores.
- req_addr  in  32  byte address (word_t).
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout.
- mem_ren  out  1  RAM read request.
- mem_wen  out  1  RAM write request.
- mem_addr  out  32  word-aligned address, req_addr with [1:0] forced to 00.
- mem_wdata  out  32  lane-replicated store data.
- mem_strobe  out  4  byte enables.
- mem_rdata  in  32  RAM read data, valid while mem_ready is high.
- mem_ready  in  1  RAM completion, sampled in RAM_WAIT.

Behaviour:
- Reset (async, immediate): state RAM_IDLE. Held at 0: resp_valid, resp_rdata, resp_err, mem_ren, mem_wen, mem_addr, mem_wdata, mem_strobe, counter.
- Reset mid-transaction aborts it: mem_ren/mem_wen drop without waiting for a clock edge, and no response is produced.
- RAM_IDLE:
  - req_ready=1.
  - On req_valid, latch wen, funct3, addr and wdata.
  - Illegal code, or misaligned address (H: addr[0]!=0; W: addr[1:0]!=0): go to RAM_DONE with resp_err set. No memory access is issued.
  - Otherwise go to RAM_WAIT and register mem_ren/mem_wen, mem_addr, mem_wdata and mem_strobe.
- Illegal codes:
  - Loads: 3, 6, 7.
  - Stores: 3 through 7.
- RAM_WAIT:
  - req_ready=0.
  - Request outputs are held stable until the cycle mem_ready is sampled high.
  - On mem_ready: drop mem_ren/mem_wen, register the formatted result, go to RAM_DONE. Minimum latency is req accept to resp_valid = 2 cycles, when mem_ready is already high in the first RAM_WAIT cycle.
- RAM_DONE:
  - resp_valid=1 for exactly one cycle, then RAM_IDLE.
  - req_ready=0, so a req_valid in this cycle is not accepted.
  - resp_rdata/resp_err hold their values until the next completion.
- Store formatting:
  - SB: mem_wdata = {4{wdata[7:0]}}, strobe = 0001 << addr[1:0].
  - SH: mem_wdata = {2{wdata[15:0]}}, strobe = 0011 << (2*addr[1]).
  - SW: mem_wdata = wdata, strobe = 1111.
- Load formatting:
  - mem_ren is asserted with strobe = 1111.
  - sh = mem_rdata >> (8*addr[1:0]).
  - LB: sign-extend sh[7:0]. LBU: zero-extend sh[7:0].
  - LH: sign-extend sh[15:0]. LHU: zero-extend sh[15:0].
  - LW: mem_rdata.
- mem_ready outside RAM_WAIT is ignored.
- req_valid outside RAM_IDLE is ignored; the requester must hold the request until it sees req_ready.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to RAM_WAIT and increments every RAM_WAIT cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES: drop mem_ren/mem_wen, go to RAM_DONE with resp_err=11 and resp_rdata=0.
  - mem_ready in that same cycle has priority and completes normally.
- Undefined: no counter logic; RAM_WAIT persists indefinitely until mem_ready, and resp_err=11 is never produced.

Test Plan:
- LB, addr 0x102, mem_rdata 0x12F45678 with mem_ready on first wait cycle -> mem_addr 0x100, resp_valid 2 cycles after accept, resp_rdata 0xFFFFFFF4, resp_err 00. Same with LBU -> 0x000000F4.
- SH, addr 0x206, wdata 0xABCD1234 -> mem_wen=1, mem_addr 0x204, mem_wdata 0x12341234, mem_strobe 1100, resp_rdata 0.
- LW, addr 0x301 -> no mem_ren ever asserted, resp_valid next cycle, resp_err 01. Store funct3=5 -> resp_err 10.
- LH, addr 0x400, mem_ready withheld 5 cycles, mem_rdata 0x00008001 -> outputs stable throughout wait, resp_rdata 0xFFFF8001 on cycle 7 after accept.
- rst asserted during RAM_WAIT of an SW -> mem_wen falls without waiting for a clock edge, no resp_valid; next request after release completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready never asserted -> resp_err 11 after 4 wait cycles, unit returns to RAM_IDLE with req_ready=1.
